// File: rtl/seg_display_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_pkg
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
//   NUM_DIGITS         : number of scanned digits
//   IDX_W              : width of the digit index
//   DEFAULT_BLANK_CODE : nibble sent to the decoder for a blanked digit
//   digit_idx_t        : digit index type (0 = rightmost digit)
// ---------------------------------------------------------------------------
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

  typedef logic [IDX_W-1:0] digit_idx_t;

endpackage : seg_display_pkg

// File: rtl/seg_display_scan_if.sv
// ---------------------------------------------------------------------------
// seg_display_scan_if
// Load/display bundle between a score producer and the scanner.
//   SCORE_IN[15:0]      : four BCD digits, [3:0] = digit 0 (rightmost)
//   DOT_MASK_IN[3:0]    : per-digit dot request, bit n = digit n
//   LOAD_IN             : request to display SCORE_IN/DOT_MASK_IN
//   BLANK_EN_IN         : enables leading-zero blanking
//   LOAD_ACK_OUT        : one-cycle pulse when a value is committed
//   BIN_OUT[3:0]        : nibble for the active digit (to 7-seg decoder)
//   DOT_OUT             : dot bit for the active digit
//   SEG_SELECT_OUT[1:0] : index of the active digit
//   FRAME_TICK_OUT      : one-cycle pulse at each frame boundary
// master = producer side, slave = scanner side.
// ---------------------------------------------------------------------------
interface seg_display_scan_if;
  import seg_display_pkg::*;

  logic [15:0]      SCORE_IN;
  logic [3:0]       DOT_MASK_IN;
  logic             LOAD_IN;
  logic             BLANK_EN_IN;
  logic             LOAD_ACK_OUT;
  logic [3:0]       BIN_OUT;
  logic             DOT_OUT;
  digit_idx_t       SEG_SELECT_OUT;
  logic             FRAME_TICK_OUT;

  modport master (
    output SCORE_IN, DOT_MASK_IN, LOAD_IN, BLANK_EN_IN,
    input  LOAD_ACK_OUT, BIN_OUT, DOT_OUT, SEG_SELECT_OUT, FRAME_TICK_OUT
  );

  modport slave (
    input  SCORE_IN, DOT_MASK_IN, LOAD_IN, BLANK_EN_IN,
    output LOAD_ACK_OUT, BIN_OUT, DOT_OUT, SEG_SELECT_OUT, FRAME_TICK_OUT
  );

endinterface : seg_display_scan_if

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler
// Free-running counter 0..DIV-1 that flags its terminal count.
//   CLK      : system clock (rising edge)
//   RESET    : synchronous active-high reset, counter returns to 0
//   TICK_OUT : high while the counter sits at DIV-1 (every cycle if DIV=1)
// TICK_OUT is decoded from the counter register only, so it carries no
// combinational path from any input.
// ---------------------------------------------------------------------------
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK_OUT
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             terminal;

  assign terminal = (cnt_reg == TERMINAL);
  assign TICK_OUT = terminal;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg <= '0;
    end else if (terminal) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule : refresh_prescaler

// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
// Time-multiplexes a 4-digit BCD score onto one 7-segment decoder.
//   CLK   : system clock (rising edge)
//   RESET : synchronous active-high reset
//   bus   : seg_display_scan_if.slave (load request in, digit drive out)
// Parameters:
//   REFRESH_DIV : clock cycles per digit slot (>= 1)
//   BLANK_CODE  : nibble emitted for a blanked leading-zero digit
//
// Loads are staged and only copied into the displayed (shadow) registers at
// a frame boundary, so a frame never mixes old and new digits. A load on
// the boundary cycle itself bypasses staging and wins over anything
// pending. Every output is a register.
// ---------------------------------------------------------------------------
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int         REFRESH_DIV = 100000,
  parameter logic [3:0] BLANK_CODE  = DEFAULT_BLANK_CODE
) (
  input  logic               CLK,
  input  logic               RESET,
  seg_display_scan_if.slave  bus
);

  localparam digit_idx_t LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic tick;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (RESET),
    .TICK_OUT (tick)
  );

  digit_idx_t  idx_reg, idx_next;
  logic [15:0] staging_score_reg, staging_score_next;
  logic [3:0]  staging_dot_reg, staging_dot_next;
  logic        pending_reg, pending_next;
  logic [15:0] shadow_score_reg, shadow_score_next;
  logic [3:0]  shadow_dot_reg, shadow_dot_next;
  logic [3:0]  bin_reg, bin_next;
  logic        dot_reg, dot_next;
  logic        ack_reg, ack_next;
  logic        frame_reg;
  logic        frame_boundary;

  assign frame_boundary = tick && (idx_reg == LAST_IDX);

  // Load staging and boundary commit.
  always_comb begin
    staging_score_next = staging_score_reg;
    staging_dot_next   = staging_dot_reg;
    pending_next       = pending_reg;
    shadow_score_next  = shadow_score_reg;
    shadow_dot_next    = shadow_dot_reg;
    ack_next           = 1'b0;
    if (frame_boundary) begin
      if (bus.LOAD_IN) begin
        // Newest request wins over a pending one; a single ack covers both.
        shadow_score_next = bus.SCORE_IN;
        shadow_dot_next   = bus.DOT_MASK_IN;
        pending_next      = 1'b0;
        ack_next          = 1'b1;
      end else if (pending_reg) begin
        shadow_score_next = staging_score_reg;
        shadow_dot_next   = staging_dot_reg;
        pending_next      = 1'b0;
        ack_next          = 1'b1;
      end
    end else if (bus.LOAD_IN) begin
      staging_score_next = bus.SCORE_IN;
      staging_dot_next   = bus.DOT_MASK_IN;
      pending_next       = 1'b1;
    end
  end

  // Per-digit value after leading-zero blanking. Built from the shadow value
  // that will be live after this edge so the first slot of a new frame
  // already shows the newly committed digit 0.
  logic [NUM_DIGITS:0] zero_from;
  logic [3:0]          digit_val [NUM_DIGITS];

  assign zero_from[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nibble;
      assign nibble        = shadow_score_next[gi*4 +: 4];
      assign zero_from[gi] = zero_from[gi+1] && (nibble == 4'd0);
      if (gi == 0) begin : g_never_blank
        assign digit_val[gi] = nibble;
      end else begin : g_blankable
        assign digit_val[gi] = (bus.BLANK_EN_IN && zero_from[gi]) ? BLANK_CODE : nibble;
      end
    end
  endgenerate

  // Scan advance; digit outputs only change on a tick.
  always_comb begin
    idx_next = idx_reg;
    bin_next = bin_reg;
    dot_next = dot_reg;
    if (tick) begin
      idx_next = idx_reg + 1'b1;
      bin_next = digit_val[idx_next];
      dot_next = shadow_dot_next[idx_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_reg           <= '0;
      staging_score_reg <= '0;
      staging_dot_reg   <= '0;
      pending_reg       <= 1'b0;
      shadow_score_reg  <= '0;
      shadow_dot_reg    <= '0;
      bin_reg           <= '0;
      dot_reg           <= 1'b0;
      ack_reg           <= 1'b0;
      frame_reg         <= 1'b0;
    end else begin
      idx_reg           <= idx_next;
      staging_score_reg <= staging_score_next;
      staging_dot_reg   <= staging_dot_next;
      pending_reg       <= pending_next;
      shadow_score_reg  <= shadow_score_next;
      shadow_dot_reg    <= shadow_dot_next;
      bin_reg           <= bin_next;
      dot_reg           <= dot_next;
      ack_reg           <= ack_next;
      frame_reg         <= frame_boundary;
    end
  end

  assign bus.SEG_SELECT_OUT = idx_reg;
  assign bus.BIN_OUT        = bin_reg;
  assign bus.DOT_OUT        = dot_reg;
  assign bus.LOAD_ACK_OUT   = ack_reg;
  assign bus.FRAME_TICK_OUT = frame_reg;

endmodule : seg_display_scan

// File: tb/tb_seg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scan
// Directed bench for seg_display_scan with REFRESH_DIV = 4 (16-cycle frame).
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// at the same point so they are stable well before the next edge.
// ---------------------------------------------------------------------------
module tb_seg_display_scan;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg_display_scan_if bus ();

  seg_display_scan #(
    .REFRESH_DIV (DIV),
    .BLANK_CODE  (4'hF)
  ) u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int checks    = 0;
  int errors    = 0;
  int ack_count = 0;
  int ack_base  = 0;

  // Counts acknowledge pulses; sampled mid-cycle, so each pulse counts once.
  always @(negedge clk) begin
    if (bus.LOAD_ACK_OUT === 1'b1) ack_count++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until FRAME_TICK_OUT is seen (bounded). With hold_chk set, the
  // display must keep showing the all-zero shadow with no ack meanwhile.
  task automatic wait_frame(input string tag, input bit hold_chk);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.FRAME_TICK_OUT === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (hold_chk) begin
        check({tag, " hold_bin"}, 16'(bus.BIN_OUT), 16'h0);
        check({tag, " hold_ack"}, 16'(bus.LOAD_ACK_OUT), 16'h0);
      end
    end
    check({tag, " frame_seen"}, 16'(found), 16'h1);
  endtask

  // Called on the frame-tick cycle; checks the four slots of one frame and
  // returns on the next frame-tick cycle.
  task automatic show_frame(input string tag, input logic [15:0] exp_val, input logic [3:0] exp_dot);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s seg%0d", tag, d), 16'(bus.SEG_SELECT_OUT), 16'(d));
      check($sformatf("%s bin%0d", tag, d), 16'(bus.BIN_OUT), 16'(exp_val[d*4 +: 4]));
      check($sformatf("%s dot%0d", tag, d), 16'(bus.DOT_OUT), 16'(exp_dot[d]));
      $display("frame %s digit %0d bin=%h dot=%b", tag, d, bus.BIN_OUT, bus.DOT_OUT);
      step(DIV);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " seg"},   16'(bus.SEG_SELECT_OUT), 16'h0);
    check({tag, " bin"},   16'(bus.BIN_OUT),        16'h0);
    check({tag, " dot"},   16'(bus.DOT_OUT),        16'h0);
    check({tag, " ack"},   16'(bus.LOAD_ACK_OUT),   16'h0);
    check({tag, " frame"}, 16'(bus.FRAME_TICK_OUT), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bus.SCORE_IN    = 16'h0;
    bus.DOT_MASK_IN = 4'h0;
    bus.LOAD_IN     = 1'b0;
    bus.BLANK_EN_IN = 1'b0;
    rst             = 1'b1;

    // Reset state.
    step(3);
    check_all_zero("reset");
    $display("reset outputs checked");

    // Free-running scan with empty shadow.
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step(1);
      check($sformatf("scan seg k%0d", k), 16'(bus.SEG_SELECT_OUT), 16'((k / 4) % 4));
      check($sformatf("scan bin k%0d", k), 16'(bus.BIN_OUT), 16'h0);
      check($sformatf("scan frame k%0d", k), 16'(bus.FRAME_TICK_OUT), 16'(k == 16));
    end
    $display("idle scan checked over 17 cycles");

    // Mid-frame load of 1234.
    step(5);
    ack_base = ack_count;
    bus.SCORE_IN = 16'h1234;
    bus.DOT_MASK_IN = 4'h0;
    bus.LOAD_IN = 1'b1;
    step(1);
    bus.LOAD_IN = 1'b0;
    $display("load 1234 mid-frame");
    wait_frame("load1234", 1'b1);
    check("load1234 ack_on_boundary", 16'(bus.LOAD_ACK_OUT), 16'h1);
    show_frame("load1234", 16'h1234, 4'b0000);
    check("load1234 ack_count", 16'(ack_count - ack_base), 16'h1);

    // Two loads before one boundary: last wins, single ack.
    ack_base = ack_count;
    bus.SCORE_IN = 16'h0011;
    bus.LOAD_IN = 1'b1;
    step(1);
    bus.SCORE_IN = 16'h0099;
    step(1);
    bus.LOAD_IN = 1'b0;
    $display("loads 0011 then 0099");
    wait_frame("twoload", 1'b0);
    show_frame("twoload", 16'h0099, 4'b0000);
    check("twoload ack_count", 16'(ack_count - ack_base), 16'h1);

    // Leading-zero blanking with dot on digit 2.
    bus.SCORE_IN = 16'h0050;
    bus.DOT_MASK_IN = 4'b0100;
    bus.BLANK_EN_IN = 1'b1;
    bus.LOAD_IN = 1'b1;
    step(1);
    bus.LOAD_IN = 1'b0;
    $display("load 0050 dot 0100 blank on");
    wait_frame("blank", 1'b0);
    show_frame("blank_on", 16'hFF50, 4'b0100);
    bus.BLANK_EN_IN = 1'b0;
    show_frame("blank_off", 16'h0050, 4'b0100);

    // Load presented exactly on the boundary cycle.
    step(15);
    check("bnd pre seg", 16'(bus.SEG_SELECT_OUT), 16'h3);
    ack_base = ack_count;
    bus.SCORE_IN = 16'h0007;
    bus.DOT_MASK_IN = 4'b0000;
    bus.LOAD_IN = 1'b1;
    step(1);
    bus.LOAD_IN = 1'b0;
    $display("load 0007 on boundary");
    check("bnd frame", 16'(bus.FRAME_TICK_OUT), 16'h1);
    check("bnd ack", 16'(bus.LOAD_ACK_OUT), 16'h1);
    show_frame("bnd", 16'h0007, 4'b0000);
    check("bnd no_second_ack", 16'(bus.LOAD_ACK_OUT), 16'h0);
    check("bnd ack_count", 16'(ack_count - ack_base), 16'h1);

    // Reset while a load is pending.
    step(3);
    ack_base = ack_count;
    bus.SCORE_IN = 16'h0088;
    bus.DOT_MASK_IN = 4'b1111;
    bus.LOAD_IN = 1'b1;
    step(1);
    bus.LOAD_IN = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    $display("reset asserted with load pending");
    check_all_zero("rst_pend");
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check($sformatf("post_rst seg k%0d", k), 16'(bus.SEG_SELECT_OUT), 16'((k / 4) % 4));
      check($sformatf("post_rst bin k%0d", k), 16'(bus.BIN_OUT), 16'h0);
      check($sformatf("post_rst dot k%0d", k), 16'(bus.DOT_OUT), 16'h0);
    end
    check("post_rst ack_count", 16'(ack_count - ack_base), 16'h0);
    $display("post-reset scan checked over 20 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seg_display_scan

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, which sets the clock cycles per digit slot (must be >= 1).
REQ-002 The block SHALL have parameter BLANK_CODE, default 4'hF, which is the nibble emitted for a blanked digit.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port SCORE_IN, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-006 The block SHALL have port DOT_MASK_IN, input, 4 bits: per-digit dot request; bit n belongs to digit n.
REQ-007 The block SHALL have port LOAD_IN, input, 1 bit: request to display SCORE_IN/DOT_MASK_IN, sampled on every cycle.
REQ-008 The block SHALL have port BLANK_EN_IN, input, 1 bit: enables leading-zero blanking.
REQ-009 The block SHALL have port LOAD_ACK_OUT, output, 1 bit: one-cycle pulse when a value is committed to the display.
REQ-010 The block SHALL have port BIN_OUT, output, 4 bits: nibble for the current digit, feeding the 7-segment decoder's binary input.
REQ-011 The block SHALL have port DOT_OUT, output, 1 bit: dot bit for the current digit, passed unchanged to the decoder's dot input.
REQ-012 The block SHALL have port SEG_SELECT_OUT, output, 2 bits: index of the active digit, 0..3.
REQ-013 The block SHALL have port FRAME_TICK_OUT, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and assert an internal tick on the terminal count; with REFRESH_DIV=1 the tick is asserted every cycle.
REQ-015 On each tick, the digit index SHALL advance 0->1->2->3->0.
REQ-016 A frame boundary SHALL be a tick while the index is 3; FRAME_TICK_OUT SHALL pulse high in the cycle after that tick.
REQ-017 BIN_OUT, DOT_OUT and SEG_SELECT_OUT SHALL be registered and reflect the new index exactly 1 cycle after the tick, holding steady between ticks.
REQ-018 Display data SHALL come from shadow registers (score and dot mask), never directly from SCORE_IN/DOT_MASK_IN.
REQ-019 LOAD_IN high SHALL capture SCORE_IN/DOT_MASK_IN into staging registers and set a pending flag.
REQ-020 If LOAD_IN is high again while pending, the staging registers SHALL be overwritten by the newest value (last wins), with no extra acknowledge.
REQ-021 At a frame boundary with pending set, the staging registers SHALL be copied to the shadow registers, pending SHALL be cleared, and LOAD_ACK_OUT SHALL pulse for 1 cycle.
REQ-022 If LOAD_IN is high in the same cycle as a frame boundary, that cycle's SCORE_IN/DOT_MASK_IN SHALL be committed directly to the shadow registers with one acknowledge.
REQ-023 Digit 0 of the new value SHALL therefore be displayed starting with the first slot after the boundary, so no frame is ever shown with mixed values.
REQ-024 With BLANK_EN_IN high, digit n (for n = 3, 2 or 1) SHALL output BLANK_CODE when shadow digit n and all higher shadow digits are 0; digit 0 SHALL never be blanked.
REQ-025 Non-BCD nibbles (A..F) SHALL be passed through unmodified.
REQ-026 DOT_OUT SHALL equal shadow dot mask bit [index], including for blanked digits.

Reset
REQ-027 RESET high at a clock edge SHALL clear the prescaler, index, shadow, staging and pending registers to 0.
REQ-028 During reset, BIN_OUT, DOT_OUT and SEG_SELECT_OUT SHALL be 0, and LOAD_ACK_OUT and FRAME_TICK_OUT SHALL be 0.
REQ-029 RESET asserted mid-frame or while a load is pending SHALL discard the pending load with no acknowledge; scanning SHALL restart from digit 0 with a full REFRESH_DIV slot.

Structure
REQ-030 Package seg_display_pkg SHALL hold NUM_DIGITS=4, IDX_W=2, DEFAULT_BLANK_CODE=4'hF and the digit-index type.
REQ-031 The prescaler SHALL be a sub-module, refresh_prescaler, with parameter DIV and ports CLK, RESET and TICK_OUT.
REQ-032 The implementation SHALL be 120-400 lines of RTL, with no combinational path from any input to any output.

Verification (REFRESH_DIV=4)
REQ-033 Reset release with no load -> SEG_SELECT_OUT steps 0,1,2,3,0 every 4 cycles, BIN_OUT=0, and FRAME_TICK_OUT pulses every 16 cycles.
REQ-034 LOAD_IN pulse with SCORE_IN=16'h1234 mid-frame -> the display is unchanged until the boundary, LOAD_ACK_OUT pulses once, and the next frame shows BIN_OUT 4,3,2,1 for digits 0..3.
REQ-035 Two loads (16'h0011 then 16'h0099) before one boundary -> a single acknowledge and the frame shows 9,9,0,0.
REQ-036 Shadow 16'h0050 with BLANK_EN_IN=1 -> digits 0..3 show 0,5,F,F; with BLANK_EN_IN=0 they show 0,5,0,0.
REQ-037 DOT_MASK_IN=4'b0100 loaded -> DOT_OUT is 1 only while SEG_SELECT_OUT=2.
REQ-038 LOAD_IN held on the boundary cycle (value 16'h0007) -> committed that cycle with one acknowledge; separately, RESET asserted while pending -> no acknowledge and all outputs 0.
